pc_reg_3bit: RTL and testbench
==============================

# pc_reg_3bit

Sequential program-counter stage for the 3-bit CPU. It holds the current PC and presents it to instruction fetch with a valid/ready handshake. It drives the PC into the 3-bit PC adder and registers the adder's result (or a jump target) back as the next PC. It also provides run/halt control, a wrap indication and a fetch counter.

## Interface
Parameters:
- RESET_PC, 3'b000, PC value loaded on reset
- CNT_W, 8, width of fetch counter

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin/resume fetching (level, sampled in IDLE/HALT)
- halt_req  input  1  stop fetching (sampled in RUN)
- ld  input  1  jump request, valid in RUN
- ld_addr  input  3  jump target
- pc_plus1  input  3  output of PC adder (pc + 1 mod 8)
- fetch_ready  input  1  fetch stage accepts current PC
- pc  output  3  current PC, drives PC adder input and fetch address
- pc_valid  output  1  pc is a valid fetch address
- halted  output  1  block in HALT state
- wrap  output  1  one-cycle pulse: increment took PC 7 -> 0
- fetch_cnt  output  CNT_W  number of completed fetch transfers, saturating

## Operation
- One clock, synchronous active-low reset: all state updates on rising clk only.
- States: IDLE, RUN, HALT (2-bit encoded).
- Reset (rst_n=0 at edge): state=IDLE, pc=RESET_PC, pc_valid=0, halted=0, wrap=0, fetch_cnt=0. Reset overrides all other inputs, mid-operation included.
- IDLE: pc_valid=0. If start=1 -> RUN.
- RUN: pc_valid=1. Transfer = pc_valid & fetch_ready. Priority each cycle: halt_req > ld > transfer increment.
  - halt_req=1 -> HALT. pc holds; any simultaneous ld or transfer is ignored and fetch_cnt does not increment.
  - ld=1 -> pc<=ld_addr regardless of fetch_ready. If a transfer occurs in the same cycle, fetch_cnt increments and pc_plus1 is discarded.
  - Transfer without ld -> pc<=pc_plus1. If pc==3'b111 and pc_plus1==3'b000, wrap=1 for the next cycle.
  - No transfer, no ld -> pc, fetch_cnt hold. pc_valid stays 1 and pc must not change while waiting.
- HALT: pc_valid=0, halted=1, pc holds. If start=1 and halt_req=0 -> RUN, resuming at the held pc.
- fetch_cnt increments by 1 on each transfer and saturates at all-ones.
- pc_plus1 is trusted; the block does no arithmetic on the PC itself.

## Timing
- All outputs are registered; none combinationally depend on inputs.
- pc_valid rises 1 cycle after the start edge in IDLE. The first transfer is possible in that cycle.
- The new pc is visible 1 cycle after the transfer/ld edge. Sustained throughput is one PC per cycle with fetch_ready=1.
- halted rises and pc_valid falls 1 cycle after the halt_req edge.
- wrap is high exactly one cycle.
- Simultaneous start and halt_req in HALT: remain in HALT.

## Configuration
- PC_WRAP_HALT_EN defined: an increment transfer at pc=7 sets pc=0 and wrap=1 and enters HALT in the same edge (halted=1, pc_valid=0 next cycle).
- PC_WRAP_HALT_EN undefined: the PC wraps 7 -> 0 silently apart from the wrap pulse, and execution continues in RUN.

## Test plan
- Reset then start=1, fetch_ready=1, adder connected, for 8 cycles -> pc sequence 0,1,...,7,0. Wrap pulses once after 7 -> 0. fetch_cnt=8. With PC_WRAP_HALT_EN, halted=1 and pc=0 after the 8th transfer.
- RUN at pc=2 with fetch_ready=0 for 3 cycles -> pc stays 2, pc_valid=1, fetch_cnt unchanged. Then fetch_ready=1 -> pc=3.
- RUN at pc=4 with ld=1, ld_addr=3'b110, fetch_ready=1 -> pc=6 next cycle, fetch_cnt +1, no wrap.
- RUN at pc=5 with halt_req=1 and ld=1 together -> HALT, pc=5, pc_valid=0, halted=1. Then start=1 -> RUN, pc_valid=1, pc=5.
- rst_n=0 during RUN at pc=3 -> next cycle pc=RESET_PC, state IDLE, all outputs 0. CNT_W=2 with 5 transfers -> fetch_cnt saturates at 3.

Source files
------------

// File: rtl/pc_reg_3bit.sv
// Program-counter stage for the 3-bit CPU: holds pc, offers it to fetch via valid/ready,
// and supports run/halt, jump load, wrap pulse and a saturating fetch counter.
// Optional build macro PC_WRAP_HALT_EN: an increment from pc=7 to pc=0 also enters HALT.
module pc_reg_3bit #(
    parameter logic [2:0]  RESET_PC = 3'b000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             ld,
    input  logic [2:0]       ld_addr,
    input  logic [2:0]       pc_plus1,
    input  logic             fetch_ready,
    output logic [2:0]       pc,
    output logic             pc_valid,
    output logic             halted,
    output logic             wrap,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam int unsigned PC_W = 3;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] HALT = 2'b10;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [PC_W-1:0]  pc_d;
    logic             wrap_d;
    logic [CNT_W-1:0] cnt_d;
    logic             transfer;

    // pc_valid mirrors RUN, so this is exactly a handshake completing this cycle
    assign transfer = pc_valid & fetch_ready;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc        <= RESET_PC;
            pc_valid  <= 1'b0;
            halted    <= 1'b0;
            wrap      <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state_q   <= state_d;
            pc        <= pc_d;
            pc_valid  <= (state_d == RUN);
            halted    <= (state_d == HALT);
            wrap      <= wrap_d;
            fetch_cnt <= cnt_d;
        end
    end

    // Next-state and next-output logic; priority in RUN is halt_req > ld > increment
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        wrap_d  = 1'b0;
        cnt_d   = fetch_cnt;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else begin
                    if (transfer && (fetch_cnt != {CNT_W{1'b1}})) begin
                        cnt_d = fetch_cnt + CNT_W'(1);
                    end
                    if (ld) begin
                        pc_d = ld_addr;
                    end else if (transfer) begin
                        pc_d = pc_plus1;
                        if ((pc == PC_W'(7)) && (pc_plus1 == PC_W'(0))) begin
                            wrap_d = 1'b1;
`ifdef PC_WRAP_HALT_EN
                            state_d = HALT;
`else
                            state_d = RUN;
`endif
                        end
                    end
                end
            end
            HALT: begin
                if (start && !halt_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_reg_3bit.sv
// Self-checking bench for pc_reg_3bit: directed steps followed by random stimulus,
// compared against a behavioural model of the PC stage.
module tb_pc_reg_3bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       halt_req;
    logic       ld;
    logic [2:0] ld_addr;
    logic       fetch_ready;

    logic [2:0] pc_a,  pc_b;
    logic [2:0] pc_plus1_a, pc_plus1_b;
    logic       pc_valid_a, pc_valid_b;
    logic       halted_a, halted_b;
    logic       wrap_a, wrap_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    // The PC adder, connected as in the CPU
    assign pc_plus1_a = 3'(pc_a + 3'd1);
    assign pc_plus1_b = 3'(pc_b + 3'd1);

    pc_reg_3bit #(.RESET_PC(3'b000), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .ld(ld), .ld_addr(ld_addr), .pc_plus1(pc_plus1_a), .fetch_ready(fetch_ready),
        .pc(pc_a), .pc_valid(pc_valid_a), .halted(halted_a), .wrap(wrap_a),
        .fetch_cnt(cnt_a)
    );

    pc_reg_3bit #(.RESET_PC(3'b000), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .ld(ld), .ld_addr(ld_addr), .pc_plus1(pc_plus1_b), .fetch_ready(fetch_ready),
        .pc(pc_b), .pc_valid(pc_valid_b), .halted(halted_b), .wrap(wrap_b),
        .fetch_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Behavioural model: mode 0 = idle, 1 = running, 2 = halted; count is unbounded
    int m_mode;
    int m_pc;
    int m_wrap;
    int m_count;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_wrap = 0; m_count = 0;
            return;
        end
        m_wrap = 0;
        if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (halt_req) begin
                m_mode = 2;
            end else begin
                if (fetch_ready) m_count = m_count + 1;
                if (ld) begin
                    m_pc = int'(ld_addr);
                end else if (fetch_ready) begin
                    if (m_pc == 7) begin
                        m_wrap = 1;
`ifdef PC_WRAP_HALT_EN
                        m_mode = 2;
`endif
                    end
                    m_pc = (m_pc + 1) % 8;
                end
            end
        end else begin
            if (start && !halt_req) m_mode = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},       int'(pc_a),       m_pc);
        check({tag, ".pc_valid"}, int'(pc_valid_a), (m_mode == 1) ? 1 : 0);
        check({tag, ".halted"},   int'(halted_a),   (m_mode == 2) ? 1 : 0);
        check({tag, ".wrap"},     int'(wrap_a),     m_wrap);
        check({tag, ".cnt8"},     int'(cnt_a),      sat(m_count, 255));
        check({tag, ".cnt2"},     int'(cnt_b),      sat(m_count, 3));
    endtask

    task automatic step(input string tag, input logic r, input logic s, input logic h,
                        input logic l, input logic [2:0] a, input logic fr);
        @(negedge clk);
        rst_n = r; start = s; halt_req = h; ld = l; ld_addr = a; fetch_ready = fr;
        model_update();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        clk = 1'b0;
        n_cmp = 0; n_err = 0;
        m_mode = 0; m_pc = 0; m_wrap = 0; m_count = 0;
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; ld = 1'b0; ld_addr = 3'd0; fetch_ready = 1'b0;

        step("reset0", 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
        step("reset1", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step("idle",   1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

        // Start, then eight back-to-back transfers through 7 -> 0
        step("start", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++) step("seq", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        step("post_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Stall at pc=2 then release
        step("resume", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step("ld2",    1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step("release", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

        // Jump with concurrent transfer
        step("ld4",   1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
        step("ld6xf", 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1);

        // Halt wins over ld, then resume at the held pc
        step("ld5",     1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        step("halt_ld", 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1);
        step("both",    1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
        step("hold",    1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step("restart", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

        // Reset in the middle of RUN at pc=3
        step("ld3",     1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        step("rst_run", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        step("after",   1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 4) == 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
